board_link: RTL and testbench

- Parametrised half-duplex-per-direction serial transceiver for board-state exchange between two FPGAs over GPIO.
- Transmit and receive run independently: TX serialises a DATA_W-bit word with its own strobe clock; RX deserialises the peer's frame.
- Ready handshake lines in both directions; timeout recovery on RX.
- Sits between game logic / NIOS PIO and the GPIO pins, next to the VGA board renderer.

---
 rtl/board_link.sv | 237 +++++++++++++++++++++++
 tb/tb_board_link.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_link.sv
// board_link: two-wire strobe/data serial link for exchanging board-state
// words between two FPGAs. TX and RX run independently; RX aborts a frame
// that stalls for TIMEOUT cycles.
// Optional feature macro: LINK_PARITY_EN (even parity bit appended after LSB).
module board_link #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              start,
    output logic              tx_busy,
    output logic              tx_done,
    input  logic              rdy_in,
    output logic              sclk_out,
    output logic              sdata_out,
    output logic              rdy_out,
    input  logic              sclk_in,
    input  logic              sdata_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_error
);

`ifdef LINK_PARITY_EN
    localparam int unsigned NBITS = DATA_W + 1;
`else
    localparam int unsigned NBITS = DATA_W;
`endif
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(NBITS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_LOW, TX_HIGH, TX_DONE} tx_state_t;
    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

    // ---------------------------------------------------------------
    // Input synchronisers
    // ---------------------------------------------------------------
    logic [1:0] rdy_sync;
    logic [1:0] sclk_sync;
    logic [1:0] sdata_sync;
    logic       sclk_last;
    logic       sclk_rise;

    // Two-flop synchronisers for the asynchronous peer lines, plus strobe history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_sync   <= '0;
            sclk_sync  <= '0;
            sdata_sync <= '0;
            sclk_last  <= 1'b0;
        end else begin
            rdy_sync   <= {rdy_sync[0], rdy_in};
            sclk_sync  <= {sclk_sync[0], sclk_in};
            sdata_sync <= {sdata_sync[0], sdata_in};
            sclk_last  <= sclk_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_last;

    // ---------------------------------------------------------------
    // Transmitter
    // ---------------------------------------------------------------
    tx_state_t         tx_state;
    tx_state_t         tx_next;
    logic [NBITS-1:0]  tx_shift;
    logic [NBITS-1:0]  tx_load;
    logic [DIV_W-1:0]  tx_div;
    logic [BIT_W-1:0]  tx_bits;
    logic              phase_end;
    logic              last_bit;

    assign phase_end = (tx_div == DIV_W'(CLK_DIV - 1));
    assign last_bit  = (tx_bits == BIT_W'(NBITS - 1));

    // Frame image loaded on start: data word, optionally followed by parity
    always_comb begin
        tx_load = '0;
`ifdef LINK_PARITY_EN
        tx_load = {tx_data, ^tx_data};
`else
        tx_load = tx_data;
`endif
    end

    // TX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_next;
    end

    // TX next-state logic
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (start)       tx_next = TX_WAIT;
            TX_WAIT: if (rdy_sync[1]) tx_next = TX_LOW;
            TX_LOW:  if (phase_end)   tx_next = TX_HIGH;
            TX_HIGH: if (phase_end)   tx_next = last_bit ? TX_DONE : TX_LOW;
            TX_DONE:                  tx_next = TX_IDLE;
            default:                  tx_next = TX_IDLE;
        endcase
    end

    // TX datapath: shift register, half-period divider and bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift <= '0;
            tx_div   <= '0;
            tx_bits  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (start) tx_shift <= tx_load;
                    tx_div  <= '0;
                    tx_bits <= '0;
                end
                TX_LOW: begin
                    tx_div <= phase_end ? '0 : tx_div + 1'b1;
                end
                TX_HIGH: begin
                    tx_div <= phase_end ? '0 : tx_div + 1'b1;
                    if (phase_end) begin
                        tx_shift <= {tx_shift[NBITS-2:0], 1'b0};
                        tx_bits  <= tx_bits + 1'b1;
                    end
                end
                default: begin
                    tx_div  <= '0;
                    tx_bits <= '0;
                end
            endcase
        end
    end

    // TX outputs decoded from state
    always_comb begin
        tx_busy   = (tx_state == TX_WAIT) || (tx_state == TX_LOW) || (tx_state == TX_HIGH);
        tx_done   = (tx_state == TX_DONE);
        sclk_out  = (tx_state == TX_HIGH);
        sdata_out = ((tx_state == TX_LOW) || (tx_state == TX_HIGH)) ? tx_shift[NBITS-1] : 1'b0;
    end

    // ---------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------
    rx_state_t         rx_state;
    rx_state_t         rx_next;
    logic [NBITS-2:0]  rx_shift;
    logic [NBITS-1:0]  rx_word;
    logic [BIT_W-1:0]  rx_bits;
    logic [TMO_W-1:0]  rx_timer;
    logic              frame_end;
    logic              timed_out;
    logic              parity_ok;

    assign rx_word   = {rx_shift, sdata_sync[1]};
    assign frame_end = (rx_state == RX_SHIFT) && sclk_rise && (rx_bits == BIT_W'(NBITS - 1));
    assign timed_out = (rx_state == RX_SHIFT) && !sclk_rise && (rx_timer == TMO_W'(TIMEOUT - 1));

    // Parity verdict for the word completing this cycle
    always_comb begin
        parity_ok = 1'b1;
`ifdef LINK_PARITY_EN
        parity_ok = ~(^rx_word);
`endif
    end

    // RX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_next;
    end

    // RX next-state logic
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (sclk_rise)              rx_next = RX_SHIFT;
            RX_SHIFT: if (frame_end || timed_out) rx_next = RX_IDLE;
            default:                              rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: capture bits, watchdog timer, result word and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_shift <= '0;
            rx_bits  <= '0;
            rx_timer <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_timer <= '0;
                    if (sclk_rise) begin
                        rx_shift <= rx_word[NBITS-2:0];
                        rx_bits  <= BIT_W'(1);
                    end
                end
                RX_SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_word[NBITS-2:0];
                        rx_bits  <= rx_bits + 1'b1;
                        rx_timer <= '0;
                        if (frame_end) begin
                            if (parity_ok) begin
                                rx_data  <= rx_word[NBITS-1 -: DATA_W];
                                rx_valid <= 1'b1;
                            end else begin
                                rx_error <= 1'b1;
                            end
                        end
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                        if (timed_out) rx_error <= 1'b1;
                    end
                end
                default: rx_timer <= '0;
            endcase
        end
    end

    // RX ready decoded from state
    always_comb begin
        rdy_out = (rx_state == RX_IDLE);
    end

endmodule

// File: tb/tb_board_link.sv
// tb_board_link: loopback bench for board_link (DATA_W=8, CLK_DIV=4, TIMEOUT=64).
// Build with +define+LINK_PARITY_EN to exercise the parity variant.
module tb_board_link;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned TIMEOUT = 64;
`ifdef LINK_PARITY_EN
    localparam int unsigned NBITS = DATA_W + 1;
`else
    localparam int unsigned NBITS = DATA_W;
`endif
    // One TX_WAIT cycle plus NBITS full strobe periods
    localparam int FRAME_BUSY = 1 + NBITS * 2 * CLK_DIV;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] tx_data;
    logic              start;
    logic              tx_busy, tx_done;
    logic              rdy_in, sclk_out, sdata_out, rdy_out;
    logic              sclk_in, sdata_in;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, rx_error;

    logic hold_rdy_low = 1'b0;
    logic ext_mode     = 1'b0;
    logic ext_sclk     = 1'b0;
    logic ext_sdata    = 1'b0;
    logic flip_en      = 1'b0;
    logic flip_active  = 1'b0;

    assign rdy_in   = hold_rdy_low ? 1'b0 : rdy_out;
    assign sclk_in  = ext_mode ? ext_sclk : sclk_out;
    assign sdata_in = ext_mode ? ext_sdata : (sdata_out ^ (flip_en & flip_active));

    board_link #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .start(start),
        .tx_busy(tx_busy), .tx_done(tx_done), .rdy_in(rdy_in),
        .sclk_out(sclk_out), .sdata_out(sdata_out), .rdy_out(rdy_out),
        .sclk_in(sclk_in), .sdata_in(sdata_in), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_error(rx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor (sampled on falling edge) ----------------
    int n_valid = 0, n_done = 0, n_err = 0, n_rise = 0, n_badw = 0;
    int hi_run = 0, lo_run = 0, busy_run = 0, last_busy_len = 0, frame_fall = 0;
    logic [DATA_W-1:0] last_rx = '0;
    logic prev_sclk = 1'b0, prev_busy = 1'b0, seen_fall = 1'b0;

    always @(negedge clk) begin
        prev_sclk <= sclk_out;
        prev_busy <= tx_busy;
        if (!rst) begin
            hi_run      <= 0;
            lo_run      <= 0;
            busy_run    <= 0;
            frame_fall  <= 0;
            seen_fall   <= 1'b0;
            flip_active <= 1'b0;
        end else begin
            if (rx_valid) begin
                n_valid <= n_valid + 1;
                last_rx <= rx_data;
            end
            if (tx_done)  n_done <= n_done + 1;
            if (rx_error) n_err  <= n_err + 1;
            if (sclk_out && !prev_sclk) begin
                n_rise <= n_rise + 1;
                hi_run <= 1;
                if (seen_fall && lo_run != CLK_DIV) n_badw <= n_badw + 1;
            end else if (sclk_out) begin
                hi_run <= hi_run + 1;
            end
            if (!sclk_out && prev_sclk) begin
                if (hi_run != CLK_DIV) n_badw <= n_badw + 1;
                lo_run     <= 1;
                seen_fall  <= 1'b1;
                frame_fall <= frame_fall + 1;
                if (frame_fall + 1 == DATA_W) flip_active <= 1'b1;
            end else if (!sclk_out) begin
                lo_run <= lo_run + 1;
            end
            if (tx_busy) begin
                busy_run <= busy_run + 1;
            end else begin
                if (prev_busy) last_busy_len <= busy_run;
                busy_run    <= 0;
                seen_fall   <= 1'b0;
                frame_fall  <= 0;
                flip_active <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    int s_valid, s_done, s_err, s_rise, s_badw;

    task automatic snap();
        s_valid = n_valid; s_done = n_done; s_err = n_err;
        s_rise  = n_rise;  s_badw = n_badw;
    endtask

    task automatic start_frame(input logic [DATA_W-1:0] w, input string tag);
        snap();
        tx_data = w;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check({tag, "_busy_on_start"}, 64'(tx_busy), 64'd1);
    endtask

    task automatic finish_frame(input logic [DATA_W-1:0] exp_rx, input int exp_valid,
                                input int exp_err, input int exp_strobes,
                                input bit check_len, input string tag);
        int t = 0;
        while (n_done == s_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        check({tag, "_tx_done_count"}, 64'(n_done - s_done), 64'd1);
        check({tag, "_rx_valid_count"}, 64'(n_valid - s_valid), 64'(exp_valid));
        check({tag, "_rx_error_count"}, 64'(n_err - s_err), 64'(exp_err));
        check({tag, "_strobes"}, 64'(n_rise - s_rise), 64'(exp_strobes));
        check({tag, "_strobe_widths_bad"}, 64'(n_badw - s_badw), 64'd0);
        check({tag, "_rx_data"}, 64'(rx_data), 64'(exp_rx));
        check({tag, "_busy_after"}, 64'(tx_busy), 64'd0);
        check({tag, "_rdy_out_after"}, 64'(rdy_out), 64'd1);
        if (check_len) check({tag, "_busy_cycles"}, 64'(last_busy_len), 64'(FRAME_BUSY));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_rx;
        int                exp_strobes;
    } vec_t;

    vec_t vecs[6];
    logic [DATA_W-1:0] exp_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] prior;
        logic [DATA_W-1:0] w;
        int t;
        int viol;

        vecs[0] = '{8'hA5, 8'hA5, NBITS};
        vecs[1] = '{8'h00, 8'h00, NBITS};
        vecs[2] = '{8'hFF, 8'hFF, NBITS};
        vecs[3] = '{8'h81, 8'h81, NBITS};
        vecs[4] = '{8'h7E, 8'h7E, NBITS};
        vecs[5] = '{8'h01, 8'h01, NBITS};

        rst = 1'b0; start = 1'b0; tx_data = '0;

        // 1. reset values and quiet period
        repeat (3) @(negedge clk);
        check("rst_tx_busy",  64'(tx_busy),  64'd0);
        check("rst_tx_done",  64'(tx_done),  64'd0);
        check("rst_sclk_out", 64'(sclk_out), 64'd0);
        check("rst_sdata_out",64'(sdata_out),64'd0);
        check("rst_rdy_out",  64'(rdy_out),  64'd1);
        check("rst_rx_data",  64'(rx_data),  64'd0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_rx_error", 64'(rx_error), 64'd0);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_strobes", 64'(n_rise),  64'd0);
        check("idle_valid",   64'(n_valid), 64'd0);
        check("idle_done",    64'(n_done),  64'd0);
        check("idle_error",   64'(n_err),   64'd0);
        check("idle_busy",    64'(tx_busy), 64'd0);

        // 2. table-driven loopback frames
        for (int i = 0; i < 6; i++) begin
            start_frame(vecs[i].data, $sformatf("vec%0d", i));
            finish_frame(vecs[i].exp_rx, 1, 0, vecs[i].exp_strobes, 1'b1, $sformatf("vec%0d", i));
        end

        // 3. peer not ready: frame must hold off
        hold_rdy_low = 1'b1;
        repeat (4) @(negedge clk);
        start_frame(8'h3C, "hs");
        viol = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sclk_out !== 1'b0 || tx_busy !== 1'b1) viol++;
        end
        check("hs_hold_violations", 64'(viol), 64'd0);
        hold_rdy_low = 1'b0;
        finish_frame(8'h3C, 1, 0, NBITS, 1'b0, "hs");

        // 4. stalled external frame times out
        prior = rx_data;
        snap();
        ext_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ext_sdata = 1'($urandom_range(0, 1));
            ext_sclk  = 1'b1;
            repeat (CLK_DIV) @(negedge clk);
            ext_sclk  = 1'b0;
            repeat (CLK_DIV) @(negedge clk);
        end
        t = 2 * CLK_DIV;
        while (n_err == s_err && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("tmo_error_count", 64'(n_err - s_err), 64'd1);
        check("tmo_delay_in_window", 64'((t >= TIMEOUT) && (t <= TIMEOUT + 6)), 64'd1);
        repeat (5) @(negedge clk);
        check("tmo_no_valid", 64'(n_valid - s_valid), 64'd0);
        check("tmo_rx_data_kept", 64'(rx_data), 64'(prior));
        check("tmo_rdy_out", 64'(rdy_out), 64'd1);
        ext_mode = 1'b0;
        repeat (5) @(negedge clk);
        start_frame(8'hC6, "post_tmo");
        finish_frame(8'hC6, 1, 0, NBITS, 1'b1, "post_tmo");

        // 5a. start re-pulsed mid-frame is ignored
        start_frame(8'h5A, "ign");
        repeat (30) @(negedge clk);
        tx_data = 8'hC3;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        finish_frame(8'h5A, 1, 0, NBITS, 1'b1, "ign");
        repeat (20) @(negedge clk);
        check("ign_no_second_frame", 64'(tx_busy), 64'd0);

        // randomized frames against the queue model
        for (int r = 0; r < 16; r++) begin
            w = DATA_W'($urandom_range(0, 255));
            exp_q.push_back(w);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            start_frame(w, $sformatf("rnd%0d", r));
            finish_frame(exp_q.pop_front(), 1, 0, NBITS, 1'b1, $sformatf("rnd%0d", r));
        end

`ifdef LINK_PARITY_EN
        // 6. corrupted parity bit is rejected, clean frame accepted
        prior   = rx_data;
        flip_en = 1'b1;
        start_frame(8'hA5, "par_flip");
        finish_frame(prior, 0, 1, NBITS, 1'b1, "par_flip");
        flip_en = 1'b0;
        start_frame(8'hA5, "par_ok");
        finish_frame(8'hA5, 1, 0, NBITS, 1'b1, "par_ok");
`endif

        // 5b. reset in the middle of a frame
        start_frame(8'h96, "abort");
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_tx_busy",  64'(tx_busy),  64'd0);
        check("abort_sclk_out", 64'(sclk_out), 64'd0);
        check("abort_sdata_out",64'(sdata_out),64'd0);
        check("abort_rdy_out",  64'(rdy_out),  64'd1);
        check("abort_rx_data",  64'(rx_data),  64'd0);
        check("abort_rx_valid", 64'(rx_valid), 64'd0);
        check("abort_tx_done",  64'(tx_done),  64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_no_valid", 64'(n_valid - s_valid), 64'd0);
        check("abort_no_done",  64'(n_done - s_done),   64'd0);
        check("abort_no_error", 64'(n_err - s_err),     64'd0);
        start_frame(8'h42, "recover");
        finish_frame(8'h42, 1, 0, NBITS, 1'b1, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
